// File: rtl/multicyc_ctrl.sv
// Launch/stall/commit controller between EX and the multi-cycle HI/LO unit.
// Define MULTICYC_CTRL_FLUSH_ABORT_EN to let flushes abandon in-flight ops via DRAIN.
module multicyc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [2:0]  issue_op,
    input  logic [31:0] issue_reg0,
    input  logic [31:0] issue_reg1,
    input  logic        flush,
    output logic        mc_req_valid,
    output logic [2:0]  mc_req_op,
    output logic [31:0] mc_req_reg0,
    output logic [31:0] mc_req_reg1,
    output logic [63:0] mc_req_hilo,
    input  logic        mc_resp_valid,
    input  logic [63:0] mc_resp_hilo,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

`ifdef MULTICYC_CTRL_FLUSH_ABORT_EN
    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [63:0] hilo_q;
    logic        op_ok;
    logic        accept;
    logic        commit;

    assign op_ok  = (issue_op != 3'd0) && (issue_op != 3'd7);
    assign accept = (state_q == IDLE) && issue_valid && op_ok && !flush;

`ifndef MULTICYC_CTRL_FLUSH_ABORT_EN
    // Flushed op still owns the unit; remember to drop its result.
    logic killed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            killed_q <= 1'b0;
        end else begin
            killed_q <= (state_d != IDLE) &&
                        (killed_q || (flush && state_q != IDLE));
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        stall        = 1'b0;
        mc_req_valid = 1'b0;
        commit       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LAUNCH;
                    stall   = 1'b1;
                end
            end
            LAUNCH, BUSY: begin
                mc_req_valid = (state_q == LAUNCH);
                stall        = !mc_resp_valid;
                if (state_q == LAUNCH) state_d = BUSY;
`ifdef MULTICYC_CTRL_FLUSH_ABORT_EN
                if (flush) begin
                    state_d = mc_resp_valid ? IDLE : DRAIN;
                end else if (mc_resp_valid) begin
                    state_d = IDLE;
                    commit  = 1'b1;
                end
`else
                if (mc_resp_valid) begin
                    state_d = IDLE;
                    commit  = !flush && !killed_q;
                end
`endif
            end
`ifdef MULTICYC_CTRL_FLUSH_ABORT_EN
            DRAIN: begin
                // Hold a waiting issue until the stale result is gone.
                stall = issue_valid && op_ok && !flush;
                if (mc_resp_valid) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hilo_q      <= '0;
            mc_req_op   <= '0;
            mc_req_reg0 <= '0;
            mc_req_reg1 <= '0;
        end else begin
            state_q <= state_d;
            if (commit) hilo_q <= mc_resp_hilo;
            if (accept) begin
                mc_req_op   <= issue_op;
                mc_req_reg0 <= issue_reg0;
                mc_req_reg1 <= issue_reg1;
            end
        end
    end

    assign mc_req_hilo = hilo_q;
    assign hi          = hilo_q[63:32];
    assign lo          = hilo_q[31:0];

endmodule

// File: tb/tb_multicyc_ctrl.sv
// Bench for multicyc_ctrl: directed scenarios plus random traffic.
// A transaction-level model tracks the in-flight op and HI/LO.
module tb_multicyc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic [31:0] issue_reg0;
    logic [31:0] issue_reg1;
    logic        flush;
    logic        mc_req_valid;
    logic [2:0]  mc_req_op;
    logic [31:0] mc_req_reg0;
    logic [31:0] mc_req_reg1;
    logic [63:0] mc_req_hilo;
    logic        mc_resp_valid;
    logic [63:0] mc_resp_hilo;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    multicyc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_op     (issue_op),
        .issue_reg0   (issue_reg0),
        .issue_reg1   (issue_reg1),
        .flush        (flush),
        .mc_req_valid (mc_req_valid),
        .mc_req_op    (mc_req_op),
        .mc_req_reg0  (mc_req_reg0),
        .mc_req_reg1  (mc_req_reg1),
        .mc_req_hilo  (mc_req_hilo),
        .mc_resp_valid(mc_resp_valid),
        .mc_resp_hilo (mc_resp_hilo),
        .stall        (stall),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    bit st_s;
    bit rq_s;

    task automatic chk1(input string name, input bit got, input bit exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit op_ok(input logic [2:0] o);
        return (o != 3'd0) && (o != 3'd7);
    endfunction

    // Model: one owned op at a time, its age since acceptance, and HI/LO.
    bit          m_busy = 1'b0;
    bit          m_live = 1'b0;
    int          m_age  = 0;
    logic [63:0] m_hilo = '0;
    logic [2:0]  m_op   = '0;
    logic [31:0] m_r0   = '0;
    logic [31:0] m_r1   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_live <= 1'b0;
            m_age  <= 0;
            m_hilo <= '0;
            m_op   <= '0;
            m_r0   <= '0;
            m_r1   <= '0;
        end else if (!m_busy) begin
            if (issue_valid && op_ok(issue_op) && !flush) begin
                m_busy <= 1'b1;
                m_live <= 1'b1;
                m_age  <= 1;
                m_op   <= issue_op;
                m_r0   <= issue_reg0;
                m_r1   <= issue_reg1;
            end
        end else begin
            m_age <= m_age + 1;
            if (mc_resp_valid) begin
                m_busy <= 1'b0;
                if (m_live && !flush) m_hilo <= mc_resp_hilo;
            end else if (flush) begin
                m_live <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        bit est;
        if (chk_en) begin
            if (!m_busy)
                est = issue_valid && op_ok(issue_op) && !flush;
            else if (m_live)
                est = !mc_resp_valid;
            else
`ifdef MULTICYC_CTRL_FLUSH_ABORT_EN
                est = issue_valid && op_ok(issue_op) && !flush;
`else
                est = !mc_resp_valid;
`endif
            chk1("stall", stall, est);
            chk1("req_valid", mc_req_valid, m_busy && (m_age == 1));
            chk32("req_op", 32'(mc_req_op), 32'(m_op));
            chk32("req_reg0", mc_req_reg0, m_r0);
            chk32("req_reg1", mc_req_reg1, m_r1);
            chk64("req_hilo", mc_req_hilo, m_hilo);
            chk32("hi", hi, m_hilo[63:32]);
            chk32("lo", lo, m_hilo[31:0]);
        end
    end

    task automatic cyc(input bit iv, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit fl, input bit rv, input logic [63:0] rh);
        issue_valid   = iv;
        issue_op      = op;
        issue_reg0    = a;
        issue_reg1    = b;
        flush         = fl;
        mc_resp_valid = rv;
        mc_resp_hilo  = rh;
        #1;
        st_s = stall;
        rq_s = mc_req_valid;
        @(posedge clk);
        #1;
    endtask

    // Issue held while stalled; response lands lat cycles after issue.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [63:0] rh,
                          output int stalls, output bit launch_rq);
        stalls = 0;
        cyc(1'b1, op, a, b, 1'b0, 1'b0, '0);
        if (st_s) stalls++;
        cyc(1'b1, op, a, b, 1'b0, 1'b0, '0);
        if (st_s) stalls++;
        launch_rq = rq_s;
        for (int i = 2; i < lat; i++) begin
            cyc(1'b1, op, a, b, 1'b0, 1'b0, '0);
            if (st_s) stalls++;
        end
        cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, rh);
        if (st_s) stalls++;
    endtask

    function automatic logic [63:0] unit_calc(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [63:0] hl);
        longint sa;
        longint sb;
        logic [63:0] r;
        int q;
        int m;
        sa = $signed(a);
        sb = $signed(b);
        r  = hl;
        case (op)
            3'd1: r = sa * sb;
            3'd2: r = {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 0) r = {a, 32'hFFFFFFFF};
                else begin
                    q = $signed(a) / $signed(b);
                    m = $signed(a) % $signed(b);
                    r = {m, q};
                end
            end
            3'd4: begin
                if (b == 0) r = {a, 32'hFFFFFFFF};
                else r = {a % b, a / b};
            end
            3'd5: r = {a, hl[31:0]};
            3'd6: r = {hl[63:32], a};
            default: r = hl;
        endcase
        return r;
    endfunction

    initial begin
        int n;
        bit r;
        bit pend;
        int cnt;
        logic [63:0] pval;
        bit prev_st;
        bit c_iv;
        logic [2:0] c_op;
        logic [31:0] c_a;
        logic [31:0] c_b;
        bit fl;
        bit rv;
        logic [63:0] rh;

        rst = 1'b1;
        cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, '0);
        chk_en = 1'b1;
        cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, '0);
        rst = 1'b0;
        chk32("rst_hi", hi, 32'd0);
        chk32("rst_lo", lo, 32'd0);
        chk32("rst_req_op", 32'(mc_req_op), 32'd0);
        chk32("rst_req_reg0", mc_req_reg0, 32'd0);
        cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, '0);
        chk1("rst_stall", st_s, 1'b0);
        chk1("rst_req_valid", rq_s, 1'b0);

        // MULT -2 * 3
        cyc(1'b1, 3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, '0);
        chk1("mult_stall_t", st_s, 1'b1);
        chk1("mult_req_t", rq_s, 1'b0);
        cyc(1'b1, 3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, '0);
        chk1("mult_req_t1", rq_s, 1'b1);
        chk32("mult_req_reg0", mc_req_reg0, 32'hFFFFFFFE);
        repeat (3) begin
            cyc(1'b1, 3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, '0);
            chk1("mult_busy_stall", st_s, 1'b1);
        end
        cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFA);
        chk1("mult_resp_stall", st_s, 1'b0);
        chk32("mult_hi", hi, 32'hFFFFFFFF);
        chk32("mult_lo", lo, 32'hFFFFFFFA);

        // MTHI then MTLO with fastest response
        run_op(3'd5, 32'hAAAA0000, '0, 4, 64'hAAAA0000_FFFFFFFA, n, r);
        chk32("mthi_hi", hi, 32'hAAAA0000);
        chk32("mtlo_req_hilo_hi", mc_req_hilo[63:32], 32'hAAAA0000);
        run_op(3'd6, 32'h12345678, '0, 2, 64'hAAAA0000_12345678, n, r);
        chk32("mtlo_stall_cycles", n, 32'd2);
        chk32("mtlo_lo", lo, 32'h12345678);
        chk32("mtlo_hi", hi, 32'hAAAA0000);

        // DIVU 100/7, then DIV by zero right behind it
        run_op(3'd4, 32'd100, 32'd7, 36, {32'd2, 32'd14}, n, r);
        chk32("divu_lo", lo, 32'd14);
        chk32("divu_hi", hi, 32'd2);
        run_op(3'd3, 32'd7, 32'd0, 5, {32'd7, 32'hFFFFFFFF}, n, r);
        chk1("div_b2b_launch", r, 1'b1);
        chk32("div_b2b_stalls", n, 32'd5);
        chk32("div0_hi", hi, 32'd7);
        chk32("div0_lo", lo, 32'hFFFFFFFF);

        // Flush five cycles into a DIV
        repeat (5) cyc(1'b1, 3'd3, 32'd50, 32'd5, 1'b0, 1'b0, '0);
        cyc(1'b1, 3'd3, 32'd50, 32'd5, 1'b1, 1'b0, '0);
        chk1("flush_cycle_stall", st_s, 1'b1);
`ifdef MULTICYC_CTRL_FLUSH_ABORT_EN
        cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, '0);
        chk1("drain_stall_low", st_s, 1'b0);
        repeat (3) begin
            cyc(1'b1, 3'd1, 32'd6, 32'd7, 1'b0, 1'b0, '0);
            chk1("drain_issue_stall", st_s, 1'b1);
        end
        cyc(1'b1, 3'd1, 32'd6, 32'd7, 1'b0, 1'b1, 64'hDEADBEEF_0BADF00D);
        chk32("drain_discard_hi", hi, 32'd7);
        chk32("drain_discard_lo", lo, 32'hFFFFFFFF);
        cyc(1'b1, 3'd1, 32'd6, 32'd7, 1'b0, 1'b0, '0);
        chk1("mult_after_drain_stall", st_s, 1'b1);
        cyc(1'b1, 3'd1, 32'd6, 32'd7, 1'b0, 1'b0, '0);
        chk1("mult_after_drain_launch", rq_s, 1'b1);
        cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 64'd42);
        chk32("mult_after_drain_lo", lo, 32'd42);
        chk32("mult_after_drain_hi", hi, 32'd0);
`else
        repeat (3) begin
            cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, '0);
            chk1("noabort_stall", st_s, 1'b1);
        end
        cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 64'hDEADBEEF_0BADF00D);
        chk1("noabort_resp_stall", st_s, 1'b0);
        chk32("noabort_discard_hi", hi, 32'd7);
        chk32("noabort_discard_lo", lo, 32'hFFFFFFFF);
`endif

        // Flush and response together in BUSY
        n = int'(lo);
        repeat (3) cyc(1'b1, 3'd2, 32'd9, 32'd9, 1'b0, 1'b0, '0);
        cyc(1'b0, 3'd0, '0, '0, 1'b1, 1'b1, 64'h11111111_11111111);
        chk32("flushresp_lo", lo, 32'(n));
        cyc(1'b1, 3'd5, 32'h55, '0, 1'b0, 1'b0, '0);
        chk1("flushresp_idle_accept", st_s, 1'b1);
        cyc(1'b1, 3'd5, 32'h55, '0, 1'b0, 1'b0, '0);
        chk1("flushresp_idle_launch", rq_s, 1'b1);
        cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 64'h00000055_00000066);
        chk32("mthi2_hi", hi, 32'h55);
        chk32("mthi2_lo", lo, 32'h66);

        // Reset mid-BUSY, then a stray response
        repeat (3) cyc(1'b1, 3'd1, 32'd3, 32'd4, 1'b0, 1'b0, '0);
        rst = 1'b1;
        cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, '0);
        rst = 1'b0;
        cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFF);
        chk1("stray_stall", st_s, 1'b0);
        chk32("stray_hi", hi, 32'd0);
        chk32("stray_lo", lo, 32'd0);

        // Random traffic with a responding unit model
        pend    = 1'b0;
        cnt     = 0;
        pval    = '0;
        prev_st = 1'b0;
        c_iv    = 1'b0;
        c_op    = 3'd0;
        c_a     = '0;
        c_b     = '0;
        for (int c = 0; c < 4000; c++) begin
            fl  = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 499) == 0);
            rv  = pend && (cnt == 0);
            rh  = pval;
            if (!pend && !prev_st && ($urandom_range(0, 19) == 0)) begin
                rv = 1'b1;
                rh = {$urandom, $urandom};
            end
            cyc(c_iv, c_op, c_a, c_b, fl, rv, rh);
            rst = 1'b0;
            if (pend) begin
                if (rv) pend = 1'b0;
                else cnt--;
            end
            if (rq_s) begin
                pend = 1'b1;
                cnt  = $urandom_range(0, 9);
                pval = unit_calc(mc_req_op, mc_req_reg0, mc_req_reg1, mc_req_hilo);
            end
            prev_st = st_s;
            if (!st_s || fl) begin
                c_iv = 1'($urandom_range(0, 1));
                c_op = 3'($urandom_range(0, 7));
                c_a  = $urandom;
                c_b  = $urandom_range(0, 20);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
